// File: rtl/mem_rr_arbiter_if.sv
// Signal bundle between mem_rr_arbiter, its clients and the shared memory port.
// The master view belongs to the arbiter; the slave view belongs to clients and memory.
interface mem_rr_arbiter_if #(
  parameter int unsigned M_WIDTH    = 8,
  parameter int unsigned CLIENT_CNT = 4
);
  logic [CLIENT_CNT-1:0]         client_requests;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_addrs_packed;
  logic [CLIENT_CNT-1:0]         client_wes;
  logic [2*CLIENT_CNT-1:0]       client_data_widths_packed;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_data_outs_packed;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_data_ins_packed;
  logic [CLIENT_CNT-1:0]         client_readies;
  logic [M_WIDTH-1:0]            mem_data_in;
  logic                          mem_ready;
  logic                          mem_request;
  logic                          mem_we_out;
  logic [M_WIDTH-1:0]            mem_addr;
  logic [M_WIDTH-1:0]            mem_data_out;
  logic [1:0]                    mem_data_width;
  logic [CLIENT_CNT-1:0]         grant;
  logic                          busy;

  modport master (
    input  client_requests,
    input  client_addrs_packed,
    input  client_wes,
    input  client_data_widths_packed,
    input  client_data_outs_packed,
    output client_data_ins_packed,
    output client_readies,
    input  mem_data_in,
    input  mem_ready,
    output mem_request,
    output mem_we_out,
    output mem_addr,
    output mem_data_out,
    output mem_data_width,
    output grant,
    output busy
  );

  modport slave (
    output client_requests,
    output client_addrs_packed,
    output client_wes,
    output client_data_widths_packed,
    output client_data_outs_packed,
    input  client_data_ins_packed,
    input  client_readies,
    output mem_data_in,
    output mem_ready,
    input  mem_request,
    input  mem_we_out,
    input  mem_addr,
    input  mem_data_out,
    input  mem_data_width,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among CLIENT_CNT clients, with a
// per-holder burst limit and a one-cycle request gap between transactions.
module mem_rr_arbiter #(
  parameter int unsigned M_WIDTH    = 8,
  parameter int unsigned CLIENT_CNT = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  mem_rr_arbiter_if.master bus
);
  localparam int unsigned IdxW = $clog2(CLIENT_CNT);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e          state_q;
  logic [IdxW-1:0] holder_q;
  logic [IdxW-1:0] last_q;
  logic [CntW-1:0] burst_cnt_q;

  logic [CLIENT_CNT-1:0] holder_oh;
  logic [CLIENT_CNT-1:0] others;
  logic [IdxW-1:0]       pick_idle;
  logic [IdxW-1:0]       pick_gap;
  logic [31:0]           h;

  // First requester after base (wrapping); base itself is the final candidate.
  function automatic logic [IdxW-1:0] rr_pick(input logic [CLIENT_CNT-1:0] reqs,
                                              input logic [IdxW-1:0]       base);
    logic [IdxW-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = base;
    found = 1'b0;
    for (int unsigned k = 1; k <= CLIENT_CNT; k++) begin
      idx = (32'(base) + k) % CLIENT_CNT;
      if (!found && reqs[idx]) begin
        pick  = IdxW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    holder_oh           = '0;
    holder_oh[holder_q] = 1'b1;
  end

  assign others    = bus.client_requests & ~holder_oh;
  assign pick_idle = rr_pick(bus.client_requests, last_q);
  assign pick_gap  = rr_pick(bus.client_requests, holder_q);
  assign h         = 32'(holder_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      holder_q    <= '0;
      last_q      <= IdxW'(CLIENT_CNT - 1);
      burst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.client_requests) begin
            holder_q    <= pick_idle;
            last_q      <= pick_idle;
            burst_cnt_q <= '0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // A holder dropping its request here does not abort; only mem_ready ends REQ.
          if (bus.mem_ready) begin
            if (burst_cnt_q != BurstMax) burst_cnt_q <= burst_cnt_q + 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (bus.client_requests[holder_q] && (burst_cnt_q < BurstMax || !(|others))) begin
            state_q <= StReq;
          end else if (|bus.client_requests) begin
            holder_q    <= pick_gap;
            last_q      <= pick_gap;
            burst_cnt_q <= '0;
            state_q     <= StReq;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from registered state; reset gates everything to zero at once.
  always_comb begin
    bus.grant                  = '0;
    bus.busy                   = 1'b0;
    bus.mem_request            = 1'b0;
    bus.mem_we_out             = 1'b0;
    bus.mem_addr               = '0;
    bus.mem_data_out           = '0;
    bus.mem_data_width         = '0;
    bus.client_readies         = '0;
    bus.client_data_ins_packed = '0;
    if (rst && state_q != StIdle) begin
      bus.grant          = holder_oh;
      bus.busy           = 1'b1;
      bus.mem_we_out     = bus.client_wes[holder_q];
      bus.mem_addr       = bus.client_addrs_packed[h*M_WIDTH +: M_WIDTH];
      bus.mem_data_out   = bus.client_data_outs_packed[h*M_WIDTH +: M_WIDTH];
      bus.mem_data_width = bus.client_data_widths_packed[h*2 +: 2];
      if (state_q == StReq) begin
        bus.mem_request                                 = 1'b1;
        bus.client_readies                              = holder_oh & {CLIENT_CNT{bus.mem_ready}};
        bus.client_data_ins_packed[h*M_WIDTH +: M_WIDTH] = bus.mem_data_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level arbitration model checked every cycle,
// plus directed scenarios with hand-computed grant orders.
module tb_mem_rr_arbiter;
  localparam int unsigned MW = 8;
  localparam int unsigned CN = 4;
  localparam int unsigned MB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.M_WIDTH(MW), .CLIENT_CNT(CN)) bus ();

  mem_rr_arbiter #(.M_WIDTH(MW), .CLIENT_CNT(CN), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [CN*MW-1:0] addrs  = {8'h53, 8'h42, 8'h31, 8'h20};
  logic [CN*MW-1:0] douts  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [CN-1:0]    wes    = 4'b0101;
  logic [2*CN-1:0]  widths = {2'b00, 2'b10, 2'b01, 2'b10};

  int            quota[CN];
  int            issued[CN];
  logic [CN-1:0] req_v;
  int            ready_delay = 1;
  int            age = 0;

  assign bus.client_requests           = req_v;
  assign bus.client_addrs_packed       = addrs;
  assign bus.client_data_outs_packed   = douts;
  assign bus.client_wes                = wes;
  assign bus.client_data_widths_packed = widths;
  assign bus.mem_data_in               = bus.mem_addr ^ 8'h5A;
  assign bus.mem_ready                 = bus.mem_request && (age == ready_delay);

  // Clients request until they have seen their quota of completions.
  always_comb begin
    req_v = '0;
    for (int i = 0; i < CN; i++) req_v[i] = issued[i] < quota[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < CN; i++) begin
      if (!rst) issued[i] <= 0;
      else if (bus.client_readies[i]) issued[i] <= issued[i] + 1;
    end
  end

  // Memory answers once a request has been pending ready_delay cycles.
  always @(posedge clk) begin
    if (!rst || !bus.mem_request || bus.mem_ready) age <= 0;
    else age <= age + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Model: owner (-1 when idle), completions in the current run, and whether in the gap.
  int m_owner = -1;
  int m_last  = CN - 1;
  int m_done  = 0;
  bit m_gap   = 1'b0;
  int log_q[$];
  int dut_q[$];
  int exp_q[$];

  function automatic int rr_next(input int base, input logic [CN-1:0] r);
    for (int k = 1; k <= CN; k++) if (r[(base + k) % CN]) return (base + k) % CN;
    return base;
  endfunction

  task automatic model_step();
    logic [CN-1:0] r;
    logic [CN-1:0] oth;
    r = req_v;
    if (!rst) begin
      m_owner = -1; m_last = CN - 1; m_done = 0; m_gap = 1'b0;
      log_q.delete();
      dut_q.delete();
    end else begin
      for (int i = 0; i < CN; i++) if (bus.client_readies[i]) dut_q.push_back(i);
      if (m_owner < 0) begin
        if (r != 0) begin
          m_owner = rr_next(m_last, r); m_last = m_owner; m_done = 0; m_gap = 1'b0;
        end
      end else if (!m_gap) begin
        if (bus.mem_ready) begin
          m_done = (m_done + 1 > MB) ? MB : m_done + 1;
          m_gap  = 1'b1;
          log_q.push_back(m_owner);
        end
      end else begin
        oth = r;
        oth[m_owner] = 1'b0;
        if (r[m_owner] && (m_done < MB || oth == 0)) begin
          m_gap = 1'b0;
        end else if (r != 0) begin
          m_owner = rr_next(m_owner, r); m_last = m_owner; m_done = 0; m_gap = 1'b0;
        end else begin
          m_owner = -1; m_gap = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [CN-1:0]    eg, er;
    logic [CN*MW-1:0] ed;
    logic [MW-1:0]    ea, eo;
    logic [1:0]       ewd;
    logic             ew, act, rq;
    act = rst && m_owner >= 0;
    rq  = act && !m_gap;
    eg = '0; er = '0; ed = '0; ea = '0; eo = '0; ewd = '0; ew = 1'b0;
    if (act) begin
      eg[m_owner] = 1'b1;
      ea  = addrs[m_owner*MW +: MW];
      eo  = douts[m_owner*MW +: MW];
      ewd = widths[m_owner*2 +: 2];
      ew  = wes[m_owner];
    end
    if (rq) begin
      ed[m_owner*MW +: MW] = bus.mem_data_in;
      if (bus.mem_ready) er[m_owner] = 1'b1;
    end
    chk("mem_request", 64'(bus.mem_request), 64'(rq));
    chk("busy", 64'(bus.busy), 64'(act));
    chk("grant", 64'(bus.grant), 64'(eg));
    chk("mem_addr", 64'(bus.mem_addr), 64'(ea));
    chk("mem_data_out", 64'(bus.mem_data_out), 64'(eo));
    chk("mem_data_width", 64'(bus.mem_data_width), 64'(ewd));
    chk("mem_we_out", 64'(bus.mem_we_out), 64'(ew));
    chk("client_readies", 64'(bus.client_readies), 64'(er));
    chk("client_data_ins", 64'(bus.client_data_ins_packed), 64'(ed));
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); compare(); end

  function automatic bit all_met();
    for (int i = 0; i < CN; i++) if (issued[i] < quota[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(all_met() && !bus.busy) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_timeout"}, 64'(n < 400), 64'(1));
  endtask

  task automatic check_log(input string name);
    chk({name, "_model_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    chk({name, "_dut_len"}, 64'(dut_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        chk($sformatf("%s_model_txn%0d", name, i), 64'(log_q[i]), 64'(exp_q[i]));
      if (i < dut_q.size())
        chk($sformatf("%s_dut_txn%0d", name, i), 64'(dut_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int n, pulses, req_cycles;
    bit addr_ok, first;
    logic [MW-1:0] a0;
    a0 = '0;
    for (int i = 0; i < CN; i++) quota[i] = 0;

    // Reset, then a lone request from client 2.
    repeat (2) @(posedge clk);
    #1;
    chk("s1_rst_grant", 64'(bus.grant), 64'(0));
    chk("s1_rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1 quota[2] = 1;
    @(posedge clk); #1;
    chk("s1_grant", 64'(bus.grant), 64'(4'b0100));
    chk("s1_mem_request", 64'(bus.mem_request), 64'(1));
    wait_done("s1");
    exp_q = '{2};
    check_log("s1");

    // Fairness: 1011 held from reset.
    for (int i = 0; i < CN; i++) quota[i] = 0;
    quota[0] = 4; quota[1] = 4; quota[3] = 4;
    do_reset();
    wait_done("s2");
    exp_q = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};
    check_log("s2");

    // Burst limit: client 2 arrives during client 1's first transaction's gap.
    for (int i = 0; i < CN; i++) quota[i] = 0;
    quota[1] = 3;
    do_reset();
    n = 0;
    while (log_q.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("s3_first_txn_timeout", 64'(n < 50), 64'(1));
    quota[2] = 1;
    wait_done("s3");
    exp_q = '{1, 1, 2, 1};
    check_log("s3");

    // Lone requester past the burst limit.
    for (int i = 0; i < CN; i++) quota[i] = 0;
    quota[3] = 5;
    do_reset();
    wait_done("s4");
    exp_q = '{3, 3, 3, 3, 3};
    check_log("s4");

    // Slow memory: ready after 4 REQ cycles, one ready pulse, stable address.
    for (int i = 0; i < CN; i++) quota[i] = 0;
    quota[0] = 1;
    ready_delay = 3;
    do_reset();
    n = 0; pulses = 0; req_cycles = 0; addr_ok = 1'b1; first = 1'b1;
    while (!(all_met() && !bus.busy) && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.mem_request) begin
        req_cycles++;
        if (first) begin a0 = bus.mem_addr; first = 1'b0; end
        else if (bus.mem_addr != a0) addr_ok = 1'b0;
        pulses += int'(bus.client_readies[0]);
      end
    end
    chk("s5_timeout", 64'(n < 100), 64'(1));
    chk("s5_ready_pulses", 64'(pulses), 64'(1));
    chk("s5_req_cycles", 64'(req_cycles), 64'(4));
    chk("s5_addr_stable", 64'(addr_ok), 64'(1));
    chk("s5_addr", 64'(a0), 64'(8'h20));

    // Reset in the middle of client 2's transaction abandons it.
    quota[2] = 1;
    n = 0;
    while (!bus.mem_request && n < 20) begin @(posedge clk); #1; n++; end
    chk("s5_req_timeout", 64'(n < 20), 64'(1));
    @(posedge clk); #1 rst = 1'b0;
    ready_delay = 1;
    for (int i = 0; i < CN; i++) quota[i] = 1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("s5_abort_busy", 64'(bus.busy), 64'(0));
    chk("s5_abort_grant", 64'(bus.grant), 64'(0));
    chk("s5_abort_mem_request", 64'(bus.mem_request), 64'(0));
    @(posedge clk); #1;
    chk("s5_rearb_grant", 64'(bus.grant), 64'(4'b0001));
    wait_done("s5b");
    exp_q = '{0, 1, 2, 3};
    check_log("s5b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_total);
    $fatal(1);
  end
endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter M_WIDTH, default 8: address and data width.
REQ-002 Parameter CLIENT_CNT, default 4: requester count; SHALL be at least 2.
REQ-003 Parameter MAX_BURST, default 4: consecutive transactions a holder may take while others wait; SHALL be at least 1.
REQ-004 Clocking SHALL be one clock and reset SHALL be synchronous and active-low.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 client_requests  in  CLIENT_CNT  per-client request, held until that client's ready.
REQ-008 client_addrs_packed  in  CLIENT_CNT*M_WIDTH  client i at bits [i*M_WIDTH +: M_WIDTH].
REQ-009 client_wes  in  CLIENT_CNT  per-client write enable.
REQ-010 client_data_widths_packed  in  2*CLIENT_CNT  per-client access width: 00=8, 01=16, 10=32.
REQ-011 client_data_outs_packed  in  CLIENT_CNT*M_WIDTH  per-client write data.
REQ-012 client_data_ins_packed  out  CLIENT_CNT*M_WIDTH  per-client read data.
REQ-013 client_readies  out  CLIENT_CNT  per-client completion strobe.
REQ-014 mem_data_in, mem_ready  in  M_WIDTH, 1  memory read data and completion.
REQ-015 mem_request, mem_we_out  out  1, 1  memory request and write enable.
REQ-016 mem_addr, mem_data_out  out  M_WIDTH, M_WIDTH  memory address and write data.
REQ-017 mem_data_width  out  2  memory access width.
REQ-018 grant  out  CLIENT_CNT  one-hot current holder; all zero when idle.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, REQ and GAP.
REQ-021 Registers SHALL be holder index, last-granted index last and saturating burst_cnt of width $clog2(MAX_BURST+1).
REQ-022 Round-robin pick SHALL select the first requester searching indices last+1, last+2, ... modulo CLIENT_CNT, with last included as final candidate.
REQ-023 IDLE with any request SHALL register the pick as holder and last, set burst_cnt to 0, and move to REQ; latency is request sampled at edge N, mem_request high after edge N.
REQ-024 REQ SHALL drive mem_request=1 and mem_addr, mem_data_out, mem_data_width and mem_we_out from client holder.
REQ-025 grant SHALL be one-hot at holder in REQ and GAP.
REQ-026 client_readies[holder] SHALL equal mem_ready in REQ and be 0 otherwise; every other bit SHALL be 0.
REQ-027 client_data_ins slice holder SHALL equal mem_data_in in REQ; every other slice SHALL be 0.
REQ-028 REQ with mem_ready=1 SHALL increment burst_cnt (saturating) and move to GAP; with mem_ready=0 it SHALL stay in REQ.
REQ-029 A holder dropping its request in REQ SHALL NOT abort; the arbiter waits for mem_ready.
REQ-030 GAP SHALL drive mem_request=0 for exactly one cycle, with mem_* buses still sourced from holder.
REQ-031 GAP, holder still requesting and (burst_cnt < MAX_BURST or no other requester): SHALL go to REQ with the same holder, burst continuing.
REQ-032 GAP, otherwise with any requester: SHALL pick round-robin from holder+1, update holder and last, reset burst_cnt to 0, and go to REQ.
REQ-033 GAP with no requests SHALL go to IDLE.
REQ-034 IDLE SHALL drive all outputs 0 and SHALL leave last unchanged.
REQ-035 Index wrap: with last = CLIENT_CNT-1 the search SHALL start at 0.
REQ-036 A sole requester SHALL never be starved by the burst limit.

Reset
REQ-037 While rst=0, all outputs SHALL be forced to 0 combinationally.
REQ-038 At a rising edge with rst=0: state to IDLE, holder to 0, last to CLIENT_CNT-1, burst_cnt to 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction without completing it.
REQ-040 After rst returns to 1, client 0 SHALL win the first simultaneous arbitration.

Verification (CLIENT_CNT=4, MAX_BURST=2, mem_ready one cycle after request unless stated)
REQ-041 Reset scenario: rst=0 for 2 cycles, then 1, then request=0100 -> outputs all 0 during reset; grant=0100 and mem_request=1 the cycle after the request is sampled.
REQ-042 Fairness scenario: requests 1011 held continuously from reset -> grant sequence 0001 x2, 0010 x2, 1000 x2, 0001 x2 (MAX_BURST=2), with a one-cycle mem_request gap between transactions.
REQ-043 Burst-limit scenario: client 1 continuous plus client 2 asserting mid-burst -> exactly 2 client-1 transactions, then grant=0100.
REQ-044 Lone-requester scenario: client 3 alone for 5 transactions -> grant stays 1000 throughout; mem_request pattern REQ/GAP alternating.
REQ-045 Latency and reset-abort scenario: mem_ready delayed 3 cycles -> client_readies[holder] pulses exactly 1 cycle and mem_addr is stable throughout REQ; then rst=0 during REQ -> next edge busy=0, grant=0, mem_request=0, and the next arbitration of 1111 grants 0001.
